// File: rtl/fli_index_encoder.sv
// Inverse fli immediate lookup: maps an FP register value and its format to the
// 5-bit Zfa fli index, using a 2-stage valid/ready pipeline (unbox, then match).
module fli_index_encoder #(
  parameter int FLEN          = 64,
  parameter bit ZFH_SUPPORTED = 1'b1,
  parameter bit D_SUPPORTED   = 1'b1,
  parameter bit Q_SUPPORTED   = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [FLEN-1:0] X,
  input  logic [1:0]      Fmt,
  output logic            OutValid,
  input  logic            OutReady,
  output logic            Hit,
  output logic [4:0]      Index
);

  typedef enum logic [1:0] {
    FMT_SINGLE = 2'b00,
    FMT_DOUBLE = 2'b01,
    FMT_HALF   = 2'b10,
    FMT_QUAD   = 2'b11
  } fmt_e;

  function automatic int fmtWidth(input fmt_e f);
    case (f)
      FMT_HALF:   return 16;
      FMT_SINGLE: return 32;
      FMT_DOUBLE: return 64;
      default:    return 128;
    endcase
  endfunction

  function automatic logic [FLEN-1:0] canonNan(input fmt_e f);
    case (f)
      FMT_HALF:   return FLEN'(16'h7E00);
      FMT_SINGLE: return FLEN'(32'h7FC0_0000);
      FMT_DOUBLE: return FLEN'(64'h7FF8_0000_0000_0000);
      default:    return FLEN'(128'h7FFF_8000_0000_0000_0000_0000_0000_0000);
    endcase
  endfunction

  // Finite positive entries: unbiased exponent plus the top two mantissa bits
  // ({hit, index}); every entry needs the remaining mantissa bits to be zero.
  function automatic logic [5:0] lookupNormal(input int e, input logic [1:0] m2);
    logic m0;
    logic [5:0] r;
    m0 = (m2 == 2'b00);
    r  = '0;
    case (e)
      -16: if (m0) r = {1'b1, 5'd2};
      -15: if (m0) r = {1'b1, 5'd3};
      -8:  if (m0) r = {1'b1, 5'd4};
      -7:  if (m0) r = {1'b1, 5'd5};
      -4:  if (m0) r = {1'b1, 5'd6};
      -3:  if (m0) r = {1'b1, 5'd7};
      -2:  r = {1'b1, 5'd8 + 5'(m2)};
      -1:  r = {1'b1, 5'd12 + 5'(m2)};
      0:   r = {1'b1, 5'd16 + 5'(m2)};
      1:   if (m2 != 2'b11) r = {1'b1, 5'd20 + 5'(m2)};
      2:   if (m0) r = {1'b1, 5'd23};
      3:   if (m0) r = {1'b1, 5'd24};
      4:   if (m0) r = {1'b1, 5'd25};
      7:   if (m0) r = {1'b1, 5'd26};
      8:   if (m0) r = {1'b1, 5'd27};
      15:  if (m0) r = {1'b1, 5'd28};
      16:  if (m0) r = {1'b1, 5'd29};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic            s1Valid_q, s1Valid_d;
  logic [FLEN-1:0] s1Val_q, s1Val_d;
  fmt_e            s1Fmt_q, s1Fmt_d;
  logic            outValid_q, outValid_d;
  logic            hit_q, hit_d;
  logic [4:0]      index_q, index_d;

  logic            s2Adv;
  int              inWidth;
  logic [FLEN-1:0] highMask;
  logic [FLEN-1:0] unboxed;

  assign s2Adv   = !outValid_q || OutReady;
  assign InReady = !s1Valid_q || s2Adv;

  // Stage 1: anything not properly NaN-boxed collapses to the canonical qNaN.
  always_comb begin
    inWidth  = fmtWidth(fmt_e'(Fmt));
    highMask = {FLEN{1'b1}} << inWidth;
    unboxed  = X & ~highMask;
    if ((X & highMask) != highMask) unboxed = canonNan(fmt_e'(Fmt));

    s1Valid_d = s1Valid_q;
    s1Val_d   = s1Val_q;
    s1Fmt_d   = s1Fmt_q;
    if (InReady) begin
      s1Valid_d = InValid;
      if (InValid) begin
        s1Val_d = unboxed;
        s1Fmt_d = fmt_e'(Fmt);
      end
    end
  end

  logic [127:0] wide;
  logic         sign, restZero, qnanMant, fmtOk;
  logic [14:0]  expField, expMax;
  int           bias;
  logic [1:0]   m2;
  logic [5:0]   normEnc;
  logic         matchHit;
  logic [4:0]   matchIdx;

  // Stage 2: split the stored value into common fields, then classify.
  always_comb begin
    wide     = 128'(s1Val_q);
    sign     = 1'b0;
    expField = '0;
    expMax   = '1;
    bias     = 0;
    m2       = '0;
    restZero = 1'b0;
    qnanMant = 1'b0;
    fmtOk    = 1'b0;
    case (s1Fmt_q)
      FMT_HALF: begin
        sign = wide[15]; expField = 15'(wide[14:10]); expMax = 15'h1F; bias = 15;
        m2 = wide[9:8]; restZero = (wide[7:0] == '0);
        qnanMant = wide[9] && (wide[8:0] == '0);
        fmtOk = ZFH_SUPPORTED;
      end
      FMT_SINGLE: begin
        sign = wide[31]; expField = 15'(wide[30:23]); expMax = 15'hFF; bias = 127;
        m2 = wide[22:21]; restZero = (wide[20:0] == '0);
        qnanMant = wide[22] && (wide[21:0] == '0);
        fmtOk = 1'b1;
      end
      FMT_DOUBLE: begin
        sign = wide[63]; expField = 15'(wide[62:52]); expMax = 15'h7FF; bias = 1023;
        m2 = wide[51:50]; restZero = (wide[49:0] == '0);
        qnanMant = wide[51] && (wide[50:0] == '0);
        fmtOk = D_SUPPORTED && (FLEN >= 64);
      end
      default: begin
        sign = wide[127]; expField = wide[126:112]; expMax = 15'h7FFF; bias = 16383;
        m2 = wide[111:110]; restZero = (wide[109:0] == '0);
        qnanMant = wide[111] && (wide[110:0] == '0);
        fmtOk = Q_SUPPORTED && (FLEN >= 128);
      end
    endcase

    normEnc  = lookupNormal(int'(expField) - bias, m2);
    matchHit = 1'b0;
    matchIdx = '0;
    if (!fmtOk) begin
      matchHit = 1'b0;
    end else if (expField == expMax) begin
      // Half 2^16 overflows to 7C00, so +inf reports 30 rather than 29.
      if (!sign && m2 == 2'b00 && restZero) begin
        matchHit = 1'b1; matchIdx = 5'd30;
      end else if (!sign && qnanMant) begin
        matchHit = 1'b1; matchIdx = 5'd31;
      end
    end else if (expField == '0) begin
      if (s1Fmt_q == FMT_HALF && !sign && wide[9:0] == 10'h100) begin
        matchHit = 1'b1; matchIdx = 5'd2;
      end else if (s1Fmt_q == FMT_HALF && !sign && wide[9:0] == 10'h200) begin
        matchHit = 1'b1; matchIdx = 5'd3;
      end
    end else if (restZero) begin
      if (sign) begin
        if (int'(expField) == bias && m2 == 2'b00) begin
          matchHit = 1'b1; matchIdx = 5'd0;
        end
      end else if (expField == 15'd1 && m2 == 2'b00) begin
        matchHit = 1'b1; matchIdx = 5'd1;
      end else begin
        matchHit = normEnc[5];
        matchIdx = normEnc[4:0];
      end
    end

    outValid_d = outValid_q;
    hit_d      = hit_q;
    index_d    = index_q;
    if (s2Adv) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        hit_d   = matchHit;
        index_d = matchIdx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q  <= 1'b0;
      s1Val_q    <= '0;
      s1Fmt_q    <= FMT_SINGLE;
      outValid_q <= 1'b0;
      hit_q      <= 1'b0;
      index_q    <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Val_q    <= s1Val_d;
      s1Fmt_q    <= s1Fmt_d;
      outValid_q <= outValid_d;
      hit_q      <= hit_d;
      index_q    <= index_d;
    end
  end

  assign OutValid = outValid_q;
  assign Hit      = hit_q;
  assign Index    = index_q;

endmodule

// File: tb/tb_fli_index_encoder.sv
// Directed bench for fli_index_encoder: single-item vectors with hand-computed
// indices, a backpressure burst and a mid-operation reset.
module tb_fli_index_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        InValid;
  logic        InReady;
  logic [63:0] X;
  logic [1:0]  Fmt;
  logic        OutValid;
  logic        OutReady;
  logic        Hit;
  logic [4:0]  Index;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  fli_index_encoder #(
    .FLEN(64), .ZFH_SUPPORTED(1'b1), .D_SUPPORTED(1'b1), .Q_SUPPORTED(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
    .X(X), .Fmt(Fmt), .OutValid(OutValid), .OutReady(OutReady),
    .Hit(Hit), .Index(Index)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Sends one item with the output side always ready and checks its result.
  task automatic applyStimulus(input string tag, input logic [63:0] x,
                               input logic [1:0] fmt, input logic expHit,
                               input logic [4:0] expIdx);
    @(negedge clk);
    OutReady = 1'b1;
    InValid  = 1'b1;
    X        = x;
    Fmt      = fmt;
    @(negedge clk);
    InValid = 1'b0;
    X       = '1;
    Fmt     = 2'b11;
    checkOutput({tag, ".lat1"}, OutValid, 1'b0);
    @(negedge clk);
    checkOutput({tag, ".valid"}, OutValid, 1'b1);
    checkOutput({tag, ".hit"}, Hit, expHit);
    checkOutput({tag, ".idx"}, Index, expIdx);
  endtask

  logic [63:0] bpX [5];
  logic [4:0]  bpIdx [5];
  int          k;
  int          outCount;
  logic        acc;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    X        = '0;
    Fmt      = 2'b00;
    #12;
    checkOutput("rst.valid", OutValid, 1'b0);
    checkOutput("rst.hit", Hit, 1'b0);
    checkOutput("rst.idx", Index, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("rst.inReady", InReady, 1'b1);

    applyStimulus("s1p0", 64'hFFFFFFFF3F800000, 2'b00, 1'b1, 5'd16);
    applyStimulus("dNeg1", 64'hBFF0000000000000, 2'b01, 1'b1, 5'd0);
    applyStimulus("sNeg2", 64'hFFFFFFFFC0000000, 2'b00, 1'b0, 5'd0);
    applyStimulus("dLsb", 64'h3FF0000000000001, 2'b01, 1'b0, 5'd0);
    applyStimulus("sBadNan", 64'hFFFFFFFF7FC00001, 2'b00, 1'b0, 5'd0);
    applyStimulus("hInf", 64'hFFFFFFFFFFFF7C00, 2'b10, 1'b1, 5'd30);
    applyStimulus("hSub16", 64'hFFFFFFFFFFFF0100, 2'b10, 1'b1, 5'd2);
    applyStimulus("hSub15", 64'hFFFFFFFFFFFF0200, 2'b10, 1'b1, 5'd3);
    applyStimulus("sMisBox", 64'h000000003F800000, 2'b00, 1'b1, 5'd31);
    applyStimulus("hMisBox", 64'h0000000000003C00, 2'b10, 1'b1, 5'd31);
    applyStimulus("dNegNan", 64'hFFFFFFFF00000000, 2'b01, 1'b0, 5'd0);
    applyStimulus("qUnsup", 64'h3FFF000000000000, 2'b11, 1'b0, 5'd0);
    applyStimulus("sMinNorm", 64'hFFFFFFFF00800000, 2'b00, 1'b1, 5'd1);
    applyStimulus("s0p3125", 64'hFFFFFFFF3EA00000, 2'b00, 1'b1, 5'd9);
    applyStimulus("s0p875", 64'hFFFFFFFF3F600000, 2'b00, 1'b1, 5'd15);
    applyStimulus("s3p5", 64'hFFFFFFFF40600000, 2'b00, 1'b0, 5'd0);
    applyStimulus("s2p16", 64'hFFFFFFFF47800000, 2'b00, 1'b1, 5'd29);
    applyStimulus("h2p15", 64'hFFFFFFFFFFFF7800, 2'b10, 1'b1, 5'd28);
    applyStimulus("hNeg1", 64'hFFFFFFFFFFFFBC00, 2'b10, 1'b1, 5'd0);
    applyStimulus("dInf", 64'h7FF0000000000000, 2'b01, 1'b1, 5'd30);
    applyStimulus("dQnan", 64'h7FF8000000000000, 2'b01, 1'b1, 5'd31);
    applyStimulus("d3p0", 64'h4008000000000000, 2'b01, 1'b1, 5'd22);
    applyStimulus("d2p5", 64'h4004000000000000, 2'b01, 1'b1, 5'd21);
    applyStimulus("d2m16", 64'h3EF0000000000000, 2'b01, 1'b1, 5'd2);

    // Backpressure burst: five singles while the consumer stalls for 4 cycles.
    bpX[0] = 64'hFFFFFFFFBF800000; bpIdx[0] = 5'd0;
    bpX[1] = 64'hFFFFFFFF3F800000; bpIdx[1] = 5'd16;
    bpX[2] = 64'hFFFFFFFF40000000; bpIdx[2] = 5'd20;
    bpX[3] = 64'hFFFFFFFF7F800000; bpIdx[3] = 5'd30;
    bpX[4] = 64'hFFFFFFFF7FC00000; bpIdx[4] = 5'd31;
    k = 0;
    outCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      OutReady = 1'b0;
      InValid  = 1'b1;
      X        = bpX[k];
      Fmt      = 2'b00;
      #1;
      if (c >= 2) begin
        checkOutput($sformatf("bp.stallReady%0d", c), InReady, 1'b0);
        checkOutput($sformatf("bp.stallValid%0d", c), OutValid, 1'b1);
        checkOutput($sformatf("bp.stallHit%0d", c), Hit, 1'b1);
        checkOutput($sformatf("bp.stallIdx%0d", c), Index, 5'd0);
      end
      acc = InReady;
      @(posedge clk);
      if (acc) k++;
    end
    checkOutput("bp.accepts", k, 2);

    for (int c = 0; c < 20 && outCount < 5; c++) begin
      @(negedge clk);
      OutReady = 1'b1;
      #1;
      if (OutValid) begin
        checkOutput($sformatf("bp.hit%0d", outCount), Hit, 1'b1);
        checkOutput($sformatf("bp.idx%0d", outCount), Index, bpIdx[outCount]);
        outCount++;
      end else if (outCount > 0) begin
        checkOutput("bp.gap", OutValid, 1'b1);
      end
      acc = InReady;
      if (k < 5) begin
        InValid = 1'b1;
        X       = bpX[k];
      end else begin
        InValid = 1'b0;
      end
      @(posedge clk);
      if (acc && k < 5) k++;
    end
    InValid = 1'b0;
    checkOutput("bp.count", outCount, 5);

    // Mid-operation reset with both stages occupied.
    @(negedge clk);
    OutReady = 1'b0;
    InValid  = 1'b1;
    X        = 64'hFFFFFFFF3F800000;
    Fmt      = 2'b00;
    @(negedge clk);
    X = 64'hFFFFFFFF40000000;
    @(negedge clk);
    InValid = 1'b0;
    checkOutput("mr.preValid", OutValid, 1'b1);
    checkOutput("mr.preIdx", Index, 5'd16);
    checkOutput("mr.full", InReady, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mr.valid", OutValid, 1'b0);
    checkOutput("mr.hit", Hit, 1'b0);
    checkOutput("mr.idx", Index, 5'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    OutReady = 1'b1;
    #1;
    checkOutput("mr.inReady", InReady, 1'b1);
    applyStimulus("mr.post", 64'hFFFFFFFFBF800000, 2'b00, 1'b1, 5'd0);
    @(negedge clk);
    checkOutput("mr.noStale", OutValid, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
